// File: rtl/force_release_pkg.sv
// force_release_pkg: shared types for the force/release register bank.
//   wr_op_e    - write-port operation encoding
//   ch_state_e - per-channel driver-ownership state
package force_release_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD   = 2'd0,
    OP_INVERT = 2'd1,
    OP_INCR   = 2'd2,
    OP_CLEAR  = 2'd3
  } wr_op_e;

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_FORCED = 1'b1
  } ch_state_e;

endpackage

// File: rtl/force_release_chan.sv
// force_release_chan: one channel of the force/release bank. Owns the channel
// register, its FREE/FORCED state, the pre-force shadow copy and the update mux.
// Ports:
//   clk, rst        clock, async active-high reset
//   i_force_en      level force request
//   i_force_val     value driven while forced
//   i_wr_en         accepted write targeting this channel
//   i_wr_op         write operation
//   i_wr_data       LOAD operand
//   i_tick_inv      tick edge with auto-invert enabled for this channel
//   o_val           registered channel value
//   o_forced        registered force status
//   o_busy_c        channel owned by force this cycle (combinational)
module force_release_chan
  import force_release_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0,
  parameter int unsigned      RELEASE_KEEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_force_en,
  input  logic [WIDTH-1:0] i_force_val,
  input  logic             i_wr_en,
  input  wr_op_e           i_wr_op,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_tick_inv,
  output logic [WIDTH-1:0] o_val,
  output logic             o_forced,
  output logic             o_busy_c
);

  ch_state_e        r_state;
  logic [WIDTH-1:0] r_val;
  logic [WIDTH-1:0] r_shadow;
  logic             r_forced;
  logic [WIDTH-1:0] w_wr_next;

  // Result of the requested write op applied to the current value
  always_comb begin
    w_wr_next = r_val;
    unique case (i_wr_op)
      OP_LOAD:   w_wr_next = i_wr_data;
      OP_INVERT: w_wr_next = ~r_val;
      OP_INCR:   w_wr_next = r_val + WIDTH'(1);
      OP_CLEAR:  w_wr_next = RESET_VAL;
      default:   w_wr_next = r_val;
    endcase
  end

  // The release cycle still belongs to the force, so writes are refused then too
  assign o_busy_c = (r_state == ST_FORCED) || i_force_en;

  // Channel FSM and single driver of the channel register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_FREE;
      r_val    <= RESET_VAL;
      r_shadow <= RESET_VAL;
      r_forced <= 1'b0;
    end else begin
      unique case (r_state)
        ST_FREE: begin
          if (i_force_en) begin
            r_state  <= ST_FORCED;
            r_shadow <= r_val;
            r_val    <= i_force_val;
            r_forced <= 1'b1;
          end else if (i_wr_en) begin
            r_val <= w_wr_next;
          end else if (i_tick_inv) begin
            r_val <= ~r_val;
          end
        end
        ST_FORCED: begin
          if (i_force_en) begin
            r_val <= i_force_val;
          end else begin
            r_state  <= ST_FREE;
            r_forced <= 1'b0;
            if (RELEASE_KEEP == 0) begin
              r_val <= r_shadow;
            end
          end
        end
        default: r_state <= ST_FREE;
      endcase
    end
  end

  assign o_val    = r_val;
  assign o_forced = r_forced;

endmodule

// File: rtl/force_release_reg_bank.sv
// force_release_reg_bank: NCH registers of WIDTH bits, each with a single
// procedural driver that resolves write ops, auto-invert on tick and force.
// Ports:
//   clk, rst     clock, async active-high reset
//   tick         auto-invert strobe (rising edge detected in clk domain)
//   auto_inv_en  per-channel invert-on-tick enable
//   force_en     per-channel level force request
//   force_val    per-channel force value, channel c at [c*WIDTH +: WIDTH]
//   wr_valid/wr_ready/wr_ch/wr_op/wr_data  write port
//   val_o        per-channel value
//   forced_o     per-channel force status
//   drop_cnt     saturating dropped-write count
//   drop_pulse   one-cycle pulse per dropped write
module force_release_reg_bank
  import force_release_pkg::*;
#(
  parameter int unsigned      NCH          = 4,
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0,
  parameter int unsigned      RELEASE_KEEP = 1,
  parameter int unsigned      CNT_W        = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   tick,
  input  logic [NCH-1:0]                         auto_inv_en,
  input  logic [NCH-1:0]                         force_en,
  input  logic [NCH*WIDTH-1:0]                   force_val,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
  input  logic [OP_W-1:0]                        wr_op,
  input  logic [WIDTH-1:0]                       wr_data,
  output logic [NCH*WIDTH-1:0]                   val_o,
  output logic [NCH-1:0]                         forced_o,
  output logic [CNT_W-1:0]                       drop_cnt,
  output logic                                   drop_pulse
);

  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic             r_tick_d;
  logic             r_wr_ready;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_drop_pulse;
  logic             w_tick_rise;
  logic             w_wr_acc;
  logic             w_ch_oob;
  logic             w_drop;
  logic [NCH-1:0]   w_busy_c;

  assign w_tick_rise = tick && !r_tick_d;
  assign w_wr_acc    = wr_valid && r_wr_ready;
  assign w_ch_oob    = (32'(wr_ch) >= NCH);
  assign w_drop      = w_wr_acc && (w_ch_oob || w_busy_c[wr_ch]);

  // Tick edge detect, ready-after-reset, drop pulse and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_d     <= 1'b0;
      r_wr_ready   <= 1'b0;
      r_drop_cnt   <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_tick_d     <= tick;
      r_wr_ready   <= 1'b1;
      r_drop_pulse <= w_drop;
      if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    logic w_wr_en;

    // Channel refuses the write itself while forced; the drop is accounted above
    assign w_wr_en = w_wr_acc && !w_ch_oob && (wr_ch == CH_W'(c));

    force_release_chan #(
      .WIDTH       (WIDTH),
      .RESET_VAL   (RESET_VAL),
      .RELEASE_KEEP(RELEASE_KEEP)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_force_en (force_en[c]),
      .i_force_val(force_val[c*WIDTH +: WIDTH]),
      .i_wr_en    (w_wr_en),
      .i_wr_op    (wr_op_e'(wr_op)),
      .i_wr_data  (wr_data),
      .i_tick_inv (w_tick_rise && auto_inv_en[c]),
      .o_val      (val_o[c*WIDTH +: WIDTH]),
      .o_forced   (forced_o[c]),
      .o_busy_c   (w_busy_c[c])
    );
  end

  assign wr_ready   = r_wr_ready;
  assign drop_cnt   = r_drop_cnt;
  assign drop_pulse = r_drop_pulse;

endmodule

// File: doc/force_release_reg_bank.md
Name: force_release_reg_bank

Overview:
- Parametrised bank of NCH registers, each WIDTH bits wide. Each register has exactly one procedural driver.
- Each register can be updated three ways: by procedural write ops through a valid/ready port, by auto-invert on a tick edge, or by a continuous-style override ("force"). Force has priority over everything else.
- Implements legal single-driver resolution for code that would otherwise mix continuous and procedural assignment to one variable. Release follows SV force/release semantics for variables.
- Sits in the elaboration/simulation test infrastructure as a reusable driver-resolution block.

Parameters:
- NCH, 4: number of channels.
- WIDTH, 32: bits per channel.
- RESET_VAL, 0: reset value of every channel register.
- RELEASE_KEEP, 1: behaviour on release.
  - 1: register retains the last forced value.
  - 0: register reverts to its pre-force value.
- CNT_W, 8: width of the drop counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  auto-invert strobe; its rising edge is detected in the clk domain.
- auto_inv_en  in  NCH  per-channel enable for invert-on-tick.
- force_en  in  NCH  per-channel force request; level-sensitive.
- force_val  in  NCH*WIDTH  per-channel force value; channel c occupies bits [c*WIDTH +: WIDTH].
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write port ready.
- wr_ch  in  max(1,$clog2(NCH))  target channel.
- wr_op  in  2  write operation: 0 LOAD, 1 INVERT, 2 INCR, 3 CLEAR.
- wr_data  in  WIDTH  operand for LOAD.
- val_o  out  NCH*WIDTH  registered effective value per channel.
- forced_o  out  NCH  registered per-channel force status.
- drop_cnt  out  CNT_W  saturating count of dropped writes.
- drop_pulse  out  1  one-cycle pulse per dropped write.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - Every channel register = RESET_VAL; val_o = RESET_VAL replicated.
  - forced_o = 0, drop_cnt = 0, drop_pulse = 0, wr_ready = 0.
  - Tick edge-detect flop = 0.
  - All channel states = FREE.
- wr_ready rises on the first clk edge after rst deasserts, then stays 1. A write is accepted when wr_valid && wr_ready.
- Per-channel FSM has two states, FREE and FORCED.
  - FREE -> FORCED when force_en[c] is sampled 1.
  - FORCED -> FREE when force_en[c] is sampled 0.
- On entering FORCED, the current channel value is saved to a per-channel shadow register.
- In FORCED, each cycle: channel register <= force_val[c]; forced_o[c] = 1.
- Latency: val_o and forced_o change 1 cycle after the force_en/force_val sample.
- On release:
  - RELEASE_KEEP=1: register keeps the last forced value.
  - RELEASE_KEEP=0: register <= shadow in the release cycle.
- Update priority in FREE, same cycle: write op > auto-invert tick. If both target one channel, the write is applied and that channel's tick is dropped; the tick drop is not counted.
- Write ops, with modulo-2^WIDTH arithmetic:
  - LOAD: v <= wr_data.
  - INVERT: v <= ~v.
  - INCR: v <= v+1; all-ones wraps to 0.
  - CLEAR: v <= RESET_VAL.
- Tick: a tick rising edge (tick=1, previous sample 0) inverts every FREE channel with auto_inv_en[c]=1, in that cycle.
- Dropped writes cause no register change, a drop_pulse of 1 the next cycle, and drop_cnt+1, saturating at 2^CNT_W-1. A write is dropped when:
  - it is accepted while the target channel is FORCED, or is sampled FORCED in the same cycle; or
  - wr_ch >= NCH.
- Simultaneous force assert and write in one cycle: force wins and the write is dropped.
- Simultaneous release and write in one cycle: the channel is still treated as FORCED, so the write is dropped.
- Reset mid-force: the channel returns to FREE with RESET_VAL; the shadow is discarded.

Decomposition:
- Package force_release_pkg holds:
  - typedef enum wr_op_e {OP_LOAD, OP_INVERT, OP_INCR, OP_CLEAR};
  - typedef enum ch_state_e {ST_FREE, ST_FORCED}.
- Sub-module force_release_chan: one channel's FSM, shadow, register and update mux. Instantiated NCH times under generate.
- Top level owns the write decode, the tick edge detect, and the drop counter.

Test Plan:
- Reset, then wr LOAD ch1 0x0000_00FF, then wr INVERT ch1 -> val_o ch1 = 0x0000_00FF, then 0xFFFF_FF00; wr_ready=1 from the first cycle after reset.
- force_en[2]=1 with force_val=0xDEAD_BEEF for 3 cycles, wr LOAD ch2 0x1 during force, then release:
  - val_o ch2 = 0xDEAD_BEEF; drop_cnt=1.
  - RELEASE_KEEP=1: value stays 0xDEAD_BEEF after release.
  - RELEASE_KEEP=0: value returns to its pre-force value.
- auto_inv_en=4'b0011, all values 0, tick pulse -> ch0 and ch1 = 0xFFFF_FFFF, ch2 and ch3 = 0. Holding tick high for 5 cycles causes only one inversion.
- Same cycle: tick edge plus wr LOAD ch0 0x5 with auto_inv_en[0]=1 -> ch0 = 0x5; no drop counted.
- CNT_W=2: 5 writes to a forced channel -> drop_cnt saturates at 3; drop_pulse occurs 5 times.
- Assert rst asynchronously mid-force on ch3 -> val_o=0 and forced_o=0 immediately; after release of rst, wr INCR ch3 on 0xFFFF_FFFF wraps to 0.
